reg_write_arbiter: RTL and testbench

- Arbitrates the single register-file write port between two writeback requesters: A = ALU result path, B = memory-load path.
- Drives the 5-bit destination-address mux select (`controlSignal`: 0 = A, 1 = B) and registers the winning address and data toward the register file.
- Sits between the execute/memory stages and the register file.
- Handles round-robin fairness, stall hold and suppression of writes to register 0.

---
 rtl/reg_write_arbiter.sv | 72 +++++++
 tb/tb_reg_write_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the single register-file write port (A = ALU, B = load).
// Optional same-address write coalescing is enabled by defining WRITE_COALESCE_EN.
module reg_write_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  reqA,
  input  logic [ADDR_WIDTH-1:0] addrA,
  input  logic [DATA_WIDTH-1:0] dataA,
  input  logic                  reqB,
  input  logic [ADDR_WIDTH-1:0] addrB,
  input  logic [DATA_WIDTH-1:0] dataB,
  input  logic                  stall,
  output logic                  grantA,
  output logic                  grantB,
  output logic                  controlSignal,
  output logic                  regWrite,
  output logic [ADDR_WIDTH-1:0] writeAddr,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic                  priorityB
);

  logic arb_ok;
  logic coalesce;

  // Grants are gated by resetN so nothing is accepted during a reset edge.
  assign arb_ok = resetN & ~stall;

`ifdef WRITE_COALESCE_EN
  assign coalesce = arb_ok & reqA & reqB & (addrA == addrB) & (addrA != '0);
`else
  assign coalesce = 1'b0;
`endif

  assign grantA = (arb_ok & reqA & (~reqB | ~priorityB)) | coalesce;
  assign grantB = (arb_ok & reqB & (~reqA | priorityB)) | coalesce;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      regWrite      <= 1'b0;
      writeAddr     <= '0;
      writeData     <= '0;
      controlSignal <= 1'b0;
      priorityB     <= 1'b0;
    end else begin
      // B is checked first: on a coalesced pair its data is the later write.
      if (grantB) begin
        regWrite      <= (addrB != '0);
        writeAddr     <= addrB;
        writeData     <= dataB;
        controlSignal <= 1'b1;
      end else if (grantA) begin
        regWrite      <= (addrA != '0);
        writeAddr     <= addrA;
        writeData     <= dataA;
        controlSignal <= 1'b0;
      end else begin
        regWrite      <= 1'b0;
      end

      if (!coalesce) begin
        if (grantA)      priorityB <= 1'b1;
        else if (grantB) priorityB <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus a randomized
// run compared against a transaction-level model of the arbitration rules.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        resetN;
  logic        reqA, reqB, stall;
  logic [4:0]  addrA, addrB;
  logic [31:0] dataA, dataB;
  logic        grantA, grantB, controlSignal, regWrite, priorityB;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic        m_ptr, m_we, m_cs;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        last_ga, last_gb;

  reg_write_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .resetN(resetN),
    .reqA(reqA), .addrA(addrA), .dataA(dataA),
    .reqB(reqB), .addrB(addrB), .dataB(dataB),
    .stall(stall),
    .grantA(grantA), .grantB(grantB),
    .controlSignal(controlSignal), .regWrite(regWrite),
    .writeAddr(writeAddr), .writeData(writeData),
    .priorityB(priorityB)
  );

  always #5 clk = ~clk;

  // Who should win this cycle, decided from the arbitration rules.
  function automatic void model_grants(output logic ga, output logic gb);
    logic coal;
    ga = 1'b0;
    gb = 1'b0;
    coal = 1'b0;
`ifdef WRITE_COALESCE_EN
    coal = reqA && reqB && (addrA == addrB) && (addrA != 5'd0);
`endif
    if (resetN && !stall) begin
      if (coal) begin
        ga = 1'b1;
        gb = 1'b1;
      end else if (reqA && reqB) begin
        if (m_ptr) gb = 1'b1;
        else       ga = 1'b1;
      end else begin
        ga = reqA;
        gb = reqB;
      end
    end
  endfunction

  // One clock edge; the model commits the transaction seen at that edge.
  task automatic tick();
    logic ga, gb;
    model_grants(ga, gb);
    last_ga = ga;
    last_gb = gb;
    @(posedge clk);
    if (!resetN) begin
      m_ptr = 0; m_we = 0; m_cs = 0; m_addr = 0; m_data = 0;
    end else if (ga || gb) begin
      if (gb) begin
        m_we = (addrB != 0); m_addr = addrB; m_data = dataB; m_cs = 1;
      end else begin
        m_we = (addrA != 0); m_addr = addrA; m_data = dataA; m_cs = 0;
      end
      if (!(ga && gb)) m_ptr = ga;
    end else begin
      m_we = 0;
    end
    #1;
  endtask

  task automatic apply_reset();
    resetN = 0;
    tick();
    resetN = 1;
  endtask

  task automatic test_reset();
    resetN = 0; reqA = 1; addrA = 5'd4; dataA = 32'h0404_0404;
    tick(); tick();
    checks++; if (grantA !== 1'b0) begin errors++; $display("FAIL reset_grantA: got %0h expected 0", grantA); end
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL reset_regWrite: got %0h expected 0", regWrite); end
    checks++; if (writeAddr !== 5'd0) begin errors++; $display("FAIL reset_writeAddr: got %0h expected 0", writeAddr); end
    checks++; if (writeData !== 32'd0) begin errors++; $display("FAIL reset_writeData: got %0h expected 0", writeData); end
    checks++; if (priorityB !== 1'b0) begin errors++; $display("FAIL reset_priorityB: got %0h expected 0", priorityB); end
    resetN = 1; #1;
    checks++; if (grantA !== 1'b1) begin errors++; $display("FAIL release_grantA: got %0h expected 1", grantA); end
    tick();
    reqA = 0;
    checks++; if (regWrite !== 1'b1) begin errors++; $display("FAIL release_regWrite: got %0h expected 1", regWrite); end
    checks++; if (writeAddr !== 5'd4) begin errors++; $display("FAIL release_writeAddr: got %0h expected 4", writeAddr); end
    checks++; if (writeData !== 32'h0404_0404) begin errors++; $display("FAIL release_writeData: got %0h expected 04040404", writeData); end
  endtask

  task automatic test_tie();
    apply_reset();
    reqA = 1; addrA = 5'd3; dataA = 32'hAAAA0001;
    reqB = 1; addrB = 5'd7; dataB = 32'hBBBB0002;
    #1;
    checks++; if ({grantA, grantB} !== 2'b10) begin errors++; $display("FAIL tie1_grants: got %b expected 10", {grantA, grantB}); end
    tick();
    reqA = 0;
    checks++; if (writeAddr !== 5'd3 || controlSignal !== 1'b0 || regWrite !== 1'b1)
      begin errors++; $display("FAIL tie1_write: got addr=%0d cs=%0d we=%0d expected addr=3 cs=0 we=1", writeAddr, controlSignal, regWrite); end
    checks++; if (priorityB !== 1'b1) begin errors++; $display("FAIL tie1_priorityB: got %0h expected 1", priorityB); end
    #1;
    checks++; if ({grantA, grantB} !== 2'b01) begin errors++; $display("FAIL tie2_grants: got %b expected 01", {grantA, grantB}); end
    tick();
    reqB = 0;
    checks++; if (writeAddr !== 5'd7 || controlSignal !== 1'b1 || writeData !== 32'hBBBB0002)
      begin errors++; $display("FAIL tie2_write: got addr=%0d cs=%0d data=%0h expected addr=7 cs=1 data=bbbb0002", writeAddr, controlSignal, writeData); end
    checks++; if (priorityB !== 1'b0) begin errors++; $display("FAIL tie2_priorityB: got %0h expected 0", priorityB); end
  endtask

  task automatic test_zero_reg();
    reqB = 1; addrB = 5'd0; dataB = 32'h0000DEAD;
    #1;
    checks++; if (grantB !== 1'b1) begin errors++; $display("FAIL zero_grantB: got %0h expected 1", grantB); end
    tick();
    reqB = 0;
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL zero_regWrite: got %0h expected 0", regWrite); end
    checks++; if (controlSignal !== 1'b1 || writeAddr !== 5'd0 || writeData !== 32'h0000DEAD)
      begin errors++; $display("FAIL zero_update: got cs=%0d addr=%0d data=%0h expected cs=1 addr=0 data=dead", controlSignal, writeAddr, writeData); end
  endtask

  task automatic test_stall();
    // An accept right before stall still lands in the register file.
    reqA = 1; addrA = 5'd10; dataA = 32'h1010;
    tick();
    reqA = 0; stall = 1; #1;
    checks++; if (regWrite !== 1'b1 || writeAddr !== 5'd10) begin errors++; $display("FAIL stall_complete: got we=%0d addr=%0d expected we=1 addr=10", regWrite, writeAddr); end
    reqA = 1; addrA = 5'd11; dataA = 32'h1111;
    reqB = 1; addrB = 5'd12; dataB = 32'h1212;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({grantA, grantB} !== 2'b00) begin errors++; $display("FAIL stall_grants%0d: got %b expected 00", i, {grantA, grantB}); end
      tick();
      checks++; if (regWrite !== 1'b0 || priorityB !== 1'b1) begin errors++; $display("FAIL stall_hold%0d: got we=%0d ptr=%0d expected we=0 ptr=1", i, regWrite, priorityB); end
    end
    stall = 0; #1;
    checks++; if ({grantA, grantB} !== 2'b01) begin errors++; $display("FAIL stall_release: got %b expected 01", {grantA, grantB}); end
    tick();
    reqA = 0; reqB = 0;
  endtask

  task automatic test_mid_reset();
    reqA = 1; addrA = 5'd12; dataA = 32'hC0C0;
    tick();
    checks++; if (regWrite !== 1'b1) begin errors++; $display("FAIL midrst_accept: got %0h expected 1", regWrite); end
    resetN = 0; #1;
    checks++; if (grantA !== 1'b0) begin errors++; $display("FAIL midrst_grant: got %0h expected 0", grantA); end
    tick();
    checks++; if ({regWrite, controlSignal, priorityB} !== 3'b000 || writeAddr !== 5'd0 || writeData !== 32'd0)
      begin errors++; $display("FAIL midrst_outputs: got we=%0d cs=%0d ptr=%0d addr=%0d data=%0h expected all 0", regWrite, controlSignal, priorityB, writeAddr, writeData); end
    resetN = 1; reqA = 0;
  endtask

  task automatic test_coalesce();
    apply_reset();
    reqA = 1; addrA = 5'd9; dataA = 32'h1;
    reqB = 1; addrB = 5'd9; dataB = 32'h2;
    #1;
`ifdef WRITE_COALESCE_EN
    checks++; if ({grantA, grantB} !== 2'b11) begin errors++; $display("FAIL coal_grants: got %b expected 11", {grantA, grantB}); end
    tick();
    reqA = 0; reqB = 0;
    checks++; if (writeData !== 32'h2 || writeAddr !== 5'd9 || controlSignal !== 1'b1 || regWrite !== 1'b1)
      begin errors++; $display("FAIL coal_write: got data=%0h addr=%0d cs=%0d we=%0d expected 2/9/1/1", writeData, writeAddr, controlSignal, regWrite); end
    checks++; if (priorityB !== 1'b0) begin errors++; $display("FAIL coal_priorityB: got %0h expected 0", priorityB); end
    tick();
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL coal_single: got %0h expected 0", regWrite); end
`else
    checks++; if ({grantA, grantB} !== 2'b10) begin errors++; $display("FAIL seq1_grants: got %b expected 10", {grantA, grantB}); end
    tick();
    reqA = 0;
    checks++; if (writeData !== 32'h1 || controlSignal !== 1'b0) begin errors++; $display("FAIL seq1_write: got data=%0h cs=%0d expected 1/0", writeData, controlSignal); end
    tick();
    reqB = 0;
    checks++; if (writeData !== 32'h2 || controlSignal !== 1'b1 || regWrite !== 1'b1)
      begin errors++; $display("FAIL seq2_write: got data=%0h cs=%0d we=%0d expected 2/1/1", writeData, controlSignal, regWrite); end
`endif
  endtask

  task automatic test_random();
    logic ga, gb;
    apply_reset();
    reqA = 0; reqB = 0; stall = 0;
    for (int i = 0; i < 600; i++) begin
      // New requests only once the previous one was accepted.
      if (!reqA && $urandom_range(0, 2) != 0) begin
        reqA = 1; addrA = 5'($urandom_range(0, 3)); dataA = $urandom;
      end
      if (!reqB && $urandom_range(0, 2) != 0) begin
        reqB = 1; addrB = 5'($urandom_range(0, 3)); dataB = $urandom;
      end
      stall  = ($urandom_range(0, 4) == 0);
      resetN = ($urandom_range(0, 49) != 0);
      #1;
      model_grants(ga, gb);
      checks++; if ({grantA, grantB} !== {ga, gb}) begin errors++; $display("FAIL rand_grants[%0d]: got %b expected %b", i, {grantA, grantB}, {ga, gb}); end
      tick();
      checks++; if ({regWrite, controlSignal, priorityB} !== {m_we, m_cs, m_ptr} || writeAddr !== m_addr || writeData !== m_data)
        begin errors++; $display("FAIL rand_outputs[%0d]: got we=%0d cs=%0d ptr=%0d addr=%0d data=%0h expected we=%0d cs=%0d ptr=%0d addr=%0d data=%0h",
          i, regWrite, controlSignal, priorityB, writeAddr, writeData, m_we, m_cs, m_ptr, m_addr, m_data); end
      if (last_ga) reqA = 0;
      if (last_gb) reqB = 0;
      if (reqA && $urandom_range(0, 9) == 0 && !stall) ; // keep holding while waiting
    end
    resetN = 1; stall = 0; reqA = 0; reqB = 0;
  endtask

  initial begin
    resetN = 0; reqA = 0; reqB = 0; stall = 0;
    addrA = 0; addrB = 0; dataA = 0; dataB = 0;
    m_ptr = 0; m_we = 0; m_cs = 0; m_addr = 0; m_data = 0;
    #1;
    test_reset();
    test_tie();
    test_zero_reg();
    test_stall();
    test_mid_reset();
    test_coalesce();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
